// File: rtl/shift_sequencer.sv
// -----------------------------------------------------------------------------
// shift_sequencer
//
// Multi-cycle controller that drives a combinational single-position shifter
// to perform an N-position logical shift of a WIDTH-bit operand. The operand,
// shift amount and direction are latched on start. One position is shifted
// per cycle by presenting the working register on B with the matching
// Hselect code and capturing H back into the working register.
//
// Ports:
//   clk      in   1      rising-edge clock
//   reset    in   1      asynchronous active-high reset
//   start    in   1      request pulse, honoured only when idle
//   dir      in   1      0 = right, 1 = left (latched on start)
//   amount   in   CNT_W  number of positions to shift (latched on start)
//   A        in   WIDTH  operand (latched on start)
//   abort    in   1      cancels an operation in progress
//   B        out  WIDTH  working register, to shifter
//   Hselect  out  2      00 transfer, 01 right by 1, 10 left by 1
//   H        in   WIDTH  shifter output
//   busy     out  1      high while shifting or finishing
//   done     out  1      one-cycle pulse when result updates
//   result   out  WIDTH  last completed result, held until the next one
// -----------------------------------------------------------------------------
module shift_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             dir,
  input  logic [CNT_W-1:0] amount,
  input  logic [WIDTH-1:0] A,
  input  logic             abort,
  output logic [WIDTH-1:0] B,
  output logic [1:0]       Hselect,
  input  logic [WIDTH-1:0] H,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  // fin_q marks a completed (not aborted) DONE cycle; result and done
  // follow it one edge later so done lands two edges after DONE entry.
  logic             fin_q, fin_d;
  logic             done_q;
  logic [WIDTH-1:0] result_q;
  logic [1:0]       hsel_s;

  // Next-state, datapath update and shifter control decode
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    fin_d   = 1'b0;
    hsel_s  = 2'b00;
    case (state_q)
      ST_IDLE: begin
        // start wins over abort here; abort has no meaning while idle
        if (start) begin
          work_d = A;
          cnt_d  = amount;
          dir_d  = dir;
          if (amount != CNT_ZERO) begin
            state_d = ST_SHIFT;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        hsel_s = dir_q ? 2'b10 : 2'b01;
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          work_d = H;
          cnt_d  = cnt_q - CNT_ONE;
          // the shift captured on this edge is the last one
          if (cnt_q == CNT_ONE) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SHIFT;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (abort) begin
          fin_d = 1'b0;
        end else begin
          fin_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and working-datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      work_q  <= {WIDTH{1'b0}};
      cnt_q   <= CNT_ZERO;
      dir_q   <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      fin_q   <= fin_d;
    end
  end

  // Result capture and completion pulse; work_q is stable until a new start
  // loads it, and a same-edge load still hands over the finished value here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q <= {WIDTH{1'b0}};
      done_q   <= 1'b0;
    end else begin
      done_q <= fin_q;
      if (fin_q) begin
        result_q <= work_q;
      end else begin
        result_q <= result_q;
      end
    end
  end

  assign B       = work_q;
  assign Hselect = hsel_s;
  assign busy    = (state_q == ST_SHIFT) || (state_q == ST_DONE);
  assign done    = done_q;
  assign result  = result_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// -----------------------------------------------------------------------------
// tb_shift_sequencer
//
// Directed bench for shift_sequencer. A behavioural single-position shifter
// closes the B -> H loop. Each scenario task drives its own stimulus and
// compares observations against hand-computed values.
// -----------------------------------------------------------------------------
module tb_shift_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        dir;
  logic [4:0]  amount;
  logic [31:0] A;
  logic        abort;
  logic [31:0] B;
  logic [1:0]  Hselect;
  logic [31:0] H;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_checks;
  int n_fail;

  shift_sequencer #(.WIDTH(32), .CNT_W(5)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .dir     (dir),
    .amount  (amount),
    .A       (A),
    .abort   (abort),
    .B       (B),
    .Hselect (Hselect),
    .H       (H),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  // Behavioural shifter: 00 transfer, 01 right by one, 10 left by one
  always_comb begin
    H = B;
    if (Hselect == 2'b01) H = {1'b0, B[31:1]};
    else if (Hselect == 2'b10) H = {B[30:0], 1'b0};
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for exactly one sampling edge; returns just after that edge
  task automatic do_start(input logic [31:0] a_v, input logic [4:0] amt_v, input logic dir_v);
    A      = a_v;
    amount = amt_v;
    dir    = dir_v;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    A      = 32'h0;
    amount = 5'd0;
    dir    = 1'b0;
  endtask

  // Observe max_edges edges (k=0 is the current point); counts shifter
  // codes and done pulses, and records the edge of the last done
  task automatic watch(input int max_edges, output int sh_r, output int sh_l,
                       output int dones, output int done_edge);
    sh_r = 0; sh_l = 0; dones = 0; done_edge = -1;
    for (int k = 0; k <= max_edges; k++) begin
      if (k > 0) tick();
      if (Hselect == 2'b01) sh_r++;
      if (Hselect == 2'b10) sh_l++;
      if (done) begin
        dones++;
        done_edge = k;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; dir = 1'b0; amount = 5'd0; A = 32'h0; abort = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h want 00000000", result); end
    n_checks++; if (Hselect !== 2'b00) begin n_fail++; $display("FAIL reset_hsel: got %b want 00", Hselect); end
    n_checks++; if (B !== 32'h0) begin n_fail++; $display("FAIL reset_B: got %h want 00000000", B); end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_right_shift();
    int sr, sl, nd, de;
    do_start(32'h80000000, 5'd4, 1'b0);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL right_busy: got %b want 1", busy); end
    watch(10, sr, sl, nd, de);
    n_checks++; if (sr !== 4 || sl !== 0) begin n_fail++; $display("FAIL right_hsel: got r=%0d l=%0d want r=4 l=0", sr, sl); end
    n_checks++; if (nd !== 1 || de !== 6) begin n_fail++; $display("FAIL right_done: got n=%0d edge=%0d want n=1 edge=6", nd, de); end
    n_checks++; if (result !== 32'h08000000) begin n_fail++; $display("FAIL right_result: got %h want 08000000", result); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL right_idle: got %b want 0", busy); end
  endtask

  task automatic test_left_full();
    int sr, sl, nd, de;
    do_start(32'h00000001, 5'd31, 1'b1);
    watch(36, sr, sl, nd, de);
    n_checks++; if (sl !== 31 || sr !== 0) begin n_fail++; $display("FAIL left1_hsel: got l=%0d r=%0d want l=31 r=0", sl, sr); end
    n_checks++; if (nd !== 1 || de !== 33) begin n_fail++; $display("FAIL left1_done: got n=%0d edge=%0d want n=1 edge=33", nd, de); end
    n_checks++; if (result !== 32'h80000000) begin n_fail++; $display("FAIL left1_result: got %h want 80000000", result); end
    do_start(32'hFFFFFFFF, 5'd31, 1'b1);
    watch(36, sr, sl, nd, de);
    n_checks++; if (nd !== 1 || de !== 33) begin n_fail++; $display("FAIL leftF_done: got n=%0d edge=%0d want n=1 edge=33", nd, de); end
    n_checks++; if (result !== 32'h80000000) begin n_fail++; $display("FAIL leftF_result: got %h want 80000000", result); end
  endtask

  task automatic test_zero_amount();
    int sr, sl, nd, de;
    do_start(32'hDEADBEEF, 5'd0, 1'b1);
    watch(5, sr, sl, nd, de);
    n_checks++; if (sr !== 0 || sl !== 0) begin n_fail++; $display("FAIL zero_hsel: got r=%0d l=%0d want 0 0", sr, sl); end
    n_checks++; if (nd !== 1 || de !== 2) begin n_fail++; $display("FAIL zero_done: got n=%0d edge=%0d want n=1 edge=2", nd, de); end
    n_checks++; if (result !== 32'hDEADBEEF) begin n_fail++; $display("FAIL zero_result: got %h want deadbeef", result); end
  endtask

  task automatic test_busy_reject();
    int sr, sl, nd, de;
    do_start(32'hFF000000, 5'd8, 1'b0);
    tick();
    tick();
    // spurious request in the middle of the shift, now at edge 2
    A = 32'h0; amount = 5'd3; dir = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; amount = 5'd0; dir = 1'b0;
    watch(20, sr, sl, nd, de);
    n_checks++; if (sr !== 5 || sl !== 0) begin n_fail++; $display("FAIL busy_hsel: got r=%0d l=%0d want r=5 l=0", sr, sl); end
    n_checks++; if (nd !== 1 || de !== 7) begin n_fail++; $display("FAIL busy_done: got n=%0d edge=%0d want n=1 edge=7", nd, de); end
    n_checks++; if (result !== 32'h00FF0000) begin n_fail++; $display("FAIL busy_result: got %h want 00ff0000", result); end
  endtask

  task automatic test_abort();
    int sr, sl, nd, de;
    do_start(32'h12345678, 5'd10, 1'b0);
    tick();
    tick();
    // third SHIFT cycle
    abort = 1'b1;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_pre_busy: got %b want 1", busy); end
    tick();
    abort = 1'b0;
    n_checks++; if (busy !== 1'b0 || Hselect !== 2'b00) begin n_fail++; $display("FAIL abort_idle: got busy=%b hsel=%b want 0 00", busy, Hselect); end
    watch(15, sr, sl, nd, de);
    n_checks++; if (nd !== 0) begin n_fail++; $display("FAIL abort_nodone: got %0d pulses want 0", nd); end
    n_checks++; if (result !== 32'h00FF0000) begin n_fail++; $display("FAIL abort_held: got %h want 00ff0000", result); end
    do_start(32'h00000001, 5'd1, 1'b1);
    watch(6, sr, sl, nd, de);
    n_checks++; if (sl !== 1 || nd !== 1 || de !== 3) begin n_fail++; $display("FAIL abort_next_timing: got l=%0d n=%0d edge=%0d want 1 1 3", sl, nd, de); end
    n_checks++; if (result !== 32'h00000002) begin n_fail++; $display("FAIL abort_next_result: got %h want 00000002", result); end
  endtask

  task automatic test_async_reset();
    int sr, sl, nd, de;
    do_start(32'hFFFFFFFF, 5'd20, 1'b0);
    repeat (5) tick();
    #2;
    reset = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL areset_ctl: got busy=%b done=%b want 0 0", busy, done); end
    n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL areset_result: got %h want 00000000", result); end
    n_checks++; if (Hselect !== 2'b00 || B !== 32'h0) begin n_fail++; $display("FAIL areset_path: got hsel=%b B=%h want 00 0", Hselect, B); end
    tick();
    reset = 1'b0;
    tick();
    do_start(32'h0000F0F0, 5'd4, 1'b1);
    watch(10, sr, sl, nd, de);
    n_checks++; if (nd !== 1 || de !== 6) begin n_fail++; $display("FAIL areset_after_done: got n=%0d edge=%0d want 1 6", nd, de); end
    n_checks++; if (result !== 32'h000F0F00) begin n_fail++; $display("FAIL areset_after_result: got %h want 000f0f00", result); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_right_shift();
    test_left_full();
    test_zero_amount();
    test_busy_reject();
    test_abort();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
